// File: rtl/cordic_pair_sequencer.sv
// Iterative controller for the two-iteration CORDIC pair stage.
// It loads one job, loops the stage result back NUM_PAIRS times, then pulses done with the result.
module cordic_pair_sequencer #(
  parameter int NUM_PAIRS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [18:0] in_Vx,
  input  logic signed [18:0] in_Vy,
  input  logic signed [8:0]  in_Z,
  output logic               busy,
  output logic               done,
  output logic signed [18:0] out_Vx,
  output logic signed [18:0] out_Vy,
  output logic signed [8:0]  out_Z,
  output logic signed [18:0] cu_Vx,
  output logic signed [18:0] cu_Vy,
  output logic signed [8:0]  cu_Z,
  output logic signed [2:0]  cu_i,
  input  logic signed [18:0] cu_RVx,
  input  logic signed [18:0] cu_RVy,
  input  logic signed [8:0]  cu_newZ
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] LAST_PASS = 2'(NUM_PAIRS - 1);

  state_t             state_q, state_d;
  logic        [1:0]  pass_q, pass_d;
  logic signed [18:0] wx_q, wx_d, wy_q, wy_d;
  logic signed [8:0]  wz_q, wz_d;
  logic signed [18:0] ox_q, ox_d, oy_q, oy_d;
  logic signed [8:0]  oz_q, oz_d;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wz_d    = wz_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oz_d    = oz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wx_d    = in_Vx;
          wy_d    = in_Vy;
          wz_d    = in_Z;
          pass_d  = 2'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        wx_d = cu_RVx;
        wy_d = cu_RVy;
        wz_d = cu_newZ;
        if (pass_q == LAST_PASS) begin
          ox_d    = cu_RVx;
          oy_d    = cu_RVy;
          oz_d    = cu_newZ;
          state_d = S_DONE;
        end else begin
          pass_d = pass_q + 2'd1;
        end
      end
      S_DONE: begin
        pass_d  = 2'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pass_q  <= 2'd0;
      wx_q    <= '0;
      wy_q    <= '0;
      wz_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oz_q    <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wz_q    <= wz_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oz_q    <= oz_d;
    end
  end

  // The stage sees the working regs directly; the index is forced to 0 outside RUN.
  assign cu_Vx  = wx_q;
  assign cu_Vy  = wy_q;
  assign cu_Z   = wz_q;
  assign cu_i   = (state_q == S_RUN) ? {pass_q, 1'b0} : 3'sd0;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign out_Vx = ox_q;
  assign out_Vy = oy_q;
  assign out_Z  = oz_q;

endmodule

// File: tb/tb_cordic_pair_sequencer.sv
// Directed bench for cordic_pair_sequencer using a stub pair stage (x+1, y-2, z+i or pass-through).
module tb_cordic_pair_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, ident;
  logic signed [18:0] in_vx, in_vy;
  logic signed [8:0]  in_z;

  logic               busy_a, done_a, busy_b, done_b;
  logic signed [18:0] ovx_a, ovy_a, cvx_a, cvy_a, rvx_a, rvy_a;
  logic signed [8:0]  oz_a, cz_a, nz_a;
  logic signed [2:0]  ci_a;
  logic signed [18:0] ovx_b, ovy_b, cvx_b, cvy_b, rvx_b, rvy_b;
  logic signed [8:0]  oz_b, cz_b, nz_b;
  logic signed [2:0]  ci_b;

  int n_chk = 0;
  int n_fail = 0;

  // Stub stage: index added as an unsigned pass base (0,2,4).
  always_comb begin
    if (ident) begin
      rvx_a = cvx_a;
      rvy_a = cvy_a;
      nz_a  = cz_a;
    end else begin
      rvx_a = cvx_a + 19'sd1;
      rvy_a = cvy_a - 19'sd2;
      nz_a  = cz_a + $signed({6'd0, ci_a});
    end
    rvx_b = cvx_b + 19'sd1;
    rvy_b = cvy_b - 19'sd2;
    nz_b  = cz_b + $signed({6'd0, ci_b});
  end

  cordic_pair_sequencer #(.NUM_PAIRS(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .in_Vx(in_vx), .in_Vy(in_vy), .in_Z(in_z),
    .busy(busy_a), .done(done_a),
    .out_Vx(ovx_a), .out_Vy(ovy_a), .out_Z(oz_a),
    .cu_Vx(cvx_a), .cu_Vy(cvy_a), .cu_Z(cz_a), .cu_i(ci_a),
    .cu_RVx(rvx_a), .cu_RVy(rvy_a), .cu_newZ(nz_a)
  );

  cordic_pair_sequencer #(.NUM_PAIRS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .in_Vx(in_vx), .in_Vy(in_vy), .in_Z(in_z),
    .busy(busy_b), .done(done_b),
    .out_Vx(ovx_b), .out_Vy(ovy_b), .out_Z(oz_b),
    .cu_Vx(cvx_b), .cu_Vy(cvy_b), .cu_Z(cz_b), .cu_i(ci_b),
    .cu_RVx(rvx_b), .cu_RVy(rvy_b), .cu_newZ(nz_b)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int x, input int y, input int z);
    chk({tag, "_vx"}, ovx_a, x);
    chk({tag, "_vy"}, ovy_a, y);
    chk({tag, "_z"},  oz_a,  z);
  endtask

  // Steps until done_a is seen; reports the number of edges taken.
  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while (!done_a && n < limit) begin
      tick();
      n++;
    end
    if (!done_a) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n, ndone, first, second;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ident = 1'b0;
    in_vx = '0; in_vy = '0; in_z = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ci", ci_a, 0);
    chk("rst_cvx", cvx_a, 0);
    chk_out("rst", 0, 0, 0);

    // 1: basic job, pass indices 0,2,4
    in_vx = 100; in_vy = -50; in_z = 10; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t1_busy0", busy_a, 1);
    chk("t1_ci0", ci_a, 0);
    chk("t1_cvx0", cvx_a, 100);
    tick();
    chk("t1_ci1", ci_a, 2);
    chk("t1_cvx1", cvx_a, 101);
    chk("t1_done_early", done_a, 0);
    tick();
    chk("t1_ci2", $signed({29'd0, ci_a}), 4);
    chk("t1_cz2", cz_a, 12);
    tick();
    chk("t1_done", done_a, 1);
    chk("t1_busy3", busy_a, 1);
    chk("t1_ci_done", ci_a, 0);
    chk_out("t1", 103, -56, 16);
    tick();
    chk("t1_done_pulse", done_a, 0);
    chk("t1_idle", busy_a, 0);
    chk_out("t1_hold", 103, -56, 16);

    // 2: continuous start, one job every 5 cycles
    start_a = 1'b1; ndone = 0; first = -1; second = -1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done_a) begin
        ndone++;
        if (first < 0) first = c; else if (second < 0) second = c;
        chk("t2_out_vx", ovx_a, 103);
        chk("t2_out_z", oz_a, 16);
      end
      if (first >= 0 && c == first + 1) chk("t2_gap", busy_a, 0);
    end
    start_a = 1'b0;
    chk("t2_first", first, 3);
    chk("t2_period", second - first, 5);
    chk("t2_count", ndone, 2);
    wait_done("t2_drain", 10, n);
    tick(); tick();
    chk("t2_settle", busy_a, 0);

    // 3: start during RUN is ignored
    in_vx = 100; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    in_vx = 999; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done("t3", 10, n);
    chk("t3_lat", n, 1);
    chk_out("t3", 103, -56, 16);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done_a) ndone++;
    end
    chk("t3_no_extra", ndone, 0);

    // 4: reset during second RUN cycle
    in_vx = 100; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_busy", busy_a, 0);
    chk("t4_done", done_a, 0);
    chk_out("t4", 0, 0, 0);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done_a) ndone++;
    end
    chk("t4_no_done", ndone, 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done("t4_fresh", 10, n);
    chk("t4_lat", n, 3);
    chk_out("t4_fresh", 103, -56, 16);
    tick();

    // 5: extremes through a pass-through stage
    ident = 1'b1;
    in_vx = -262144; in_vy = 262143; in_z = -256; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    in_vx = 7; in_vy = 7; in_z = 7;
    wait_done("t5", 10, n);
    chk_out("t5", -262144, 262143, -256);
    tick();
    ident = 1'b0;

    // 6: single-pass instance
    in_vx = 5; in_vy = 0; in_z = 0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("t6_busy", busy_b, 1);
    chk("t6_ci", ci_b, 0);
    chk("t6_done_early", done_b, 0);
    tick();
    chk("t6_done", done_b, 1);
    chk("t6_vx", ovx_b, 6);
    chk("t6_vy", ovy_b, -2);
    tick();
    chk("t6_idle", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
